// File: rtl/noc_pkg.sv
// Shared NoC definitions: widths, node ID and decoded-flit layouts, flit packing helper.
package noc_pkg;

    localparam int unsigned FLIT_LEN   = 256;
    localparam int unsigned VC_ID_W    = 3;
    localparam int unsigned VC_NUM     = 1 << VC_ID_W;
    localparam int unsigned VC_CREDITS = 4;
    localparam int unsigned CRD_W      = $clog2(VC_CREDITS + 1);

    localparam int unsigned NODE_ID_W  = 7;
    localparam int unsigned TXN_ID_W   = 12;
    localparam int unsigned QOS_W      = 4;
    localparam int unsigned HDR_W      = 2 * NODE_ID_W + TXN_ID_W + QOS_W;
    localparam int unsigned PAYLOAD_W  = FLIT_LEN - HDR_W;

    // Field offsets within a flit
    localparam int unsigned TGT_LSB     = 0;
    localparam int unsigned SRC_LSB     = TGT_LSB + NODE_ID_W;
    localparam int unsigned TXN_LSB     = SRC_LSB + NODE_ID_W;
    localparam int unsigned QOS_LSB     = TXN_LSB + TXN_ID_W;
    localparam int unsigned PAYLOAD_LSB = QOS_LSB + QOS_W;

    typedef struct packed {
        logic       device_id;
        logic [1:0] device_port;
        logic [1:0] y;
        logic [1:0] x;
    } node_id_t;

    // Header as seen by the receive-side decoder; MSB-first so tgt_id lands in the low bits
    typedef struct packed {
        logic [QOS_W-1:0]    qos;
        logic [TXN_ID_W-1:0] txn_id;
        node_id_t            src_id;
        node_id_t            tgt_id;
    } flit_dec_t;

    function automatic logic [FLIT_LEN-1:0] pack_flit(input flit_dec_t hdr,
                                                      input logic [PAYLOAD_W-1:0] payload);
        logic [FLIT_LEN-1:0] flit;
        flit = '0;
        flit[TGT_LSB +: NODE_ID_W]     = hdr.tgt_id;
        flit[SRC_LSB +: NODE_ID_W]     = hdr.src_id;
        flit[TXN_LSB +: TXN_ID_W]      = hdr.txn_id;
        flit[QOS_LSB +: QOS_W]         = hdr.qos;
        flit[PAYLOAD_LSB +: PAYLOAD_W] = payload;
        return flit;
    endfunction

    // Two adjacent QoS levels share one VC
    function automatic logic [VC_ID_W-1:0] qos_to_vc(input logic [QOS_W-1:0] qos);
        return qos[QOS_W-1 -: VC_ID_W];
    endfunction

endpackage

// File: rtl/flit_encoder_vc_credit_ctr.sv
// Per-VC downstream credit counter with saturating return and overflow flag.
module vc_credit_ctr
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             consume,
    input  logic             ret,
    output logic [CRD_W-1:0] count,
    output logic             overflow
);

    localparam logic [CRD_W-1:0] CrdMax = CRD_W'(VC_CREDITS);

    logic [CRD_W-1:0] count_q, count_d;

    // Next count: consume and return in the same cycle cancel out
    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (consume && !ret) begin
            count_d = count_q - 1'b1;
        end else if (ret && !consume) begin
            if (count_q == CrdMax) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register, full on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CrdMax;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flit_encoder.sv
// Transmit-side flit builder: packs a request into a flit, maps QoS to a VC and launches the
// flit from a one-entry holding buffer only when that VC has a downstream credit.
module flit_encoder
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NODE_ID_W-1:0] local_id,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NODE_ID_W-1:0] in_tgt_id,
    input  logic [TXN_ID_W-1:0]  in_txn_id,
    input  logic [QOS_W-1:0]     in_qos,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [FLIT_LEN-1:0]  out_flit,
    output logic [VC_ID_W-1:0]   out_vc,
    input  logic                 crd_rtn_valid,
    input  logic [VC_ID_W-1:0]   crd_rtn_vc,
    output logic                 crd_err
);

    logic                buf_valid_q, buf_valid_d;
    logic [FLIT_LEN-1:0] buf_flit_q, buf_flit_d;
    logic [VC_ID_W-1:0]  buf_vc_q, buf_vc_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_LEN-1:0] out_flit_q, out_flit_d;
    logic [VC_ID_W-1:0]  out_vc_q, out_vc_d;
    logic                crd_err_q, crd_err_d;

    logic [CRD_W-1:0]    credit [VC_NUM];
    logic [VC_NUM-1:0]   vc_consume;
    logic [VC_NUM-1:0]   vc_return;
    logic [VC_NUM-1:0]   vc_overflow;

    logic                drain;
    logic                accept;
    flit_dec_t           in_hdr;

    // Handshake: ready depends only on buffer state and the buffered VC's credit
    always_comb begin
        drain    = buf_valid_q && (credit[buf_vc_q] != '0);
        in_ready = !buf_valid_q || drain;
        accept   = in_valid && in_ready;
    end

    // Header assembly from the request fields
    always_comb begin
        in_hdr        = '0;
        in_hdr.tgt_id = node_id_t'(in_tgt_id);
        in_hdr.src_id = node_id_t'(local_id);
        in_hdr.txn_id = in_txn_id;
        in_hdr.qos    = in_qos;
    end

    // Per-VC consume/return strobes
    always_comb begin
        vc_consume = '0;
        vc_return  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_consume[v] = drain && (buf_vc_q == VC_ID_W'(v));
            vc_return[v]  = crd_rtn_valid && (crd_rtn_vc == VC_ID_W'(v));
        end
    end

    for (genvar g = 0; g < VC_NUM; g++) begin : gen_vc
        vc_credit_ctr u_ctr (
            .clk      (clk),
            .rst_n    (rst_n),
            .consume  (vc_consume[g]),
            .ret      (vc_return[g]),
            .count    (credit[g]),
            .overflow (vc_overflow[g])
        );
    end

    // Next state for buffer, launch registers and sticky error
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_flit_d  = buf_flit_q;
        buf_vc_d    = buf_vc_q;
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        out_vc_d    = out_vc_q;
        crd_err_d   = crd_err_q || (|vc_overflow);

        if (drain) begin
            out_valid_d = 1'b1;
            out_flit_d  = buf_flit_q;
            out_vc_d    = buf_vc_q;
            buf_valid_d = 1'b0;
        end
        // A drain frees the slot in the same cycle, so accept may refill it
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_flit_d  = pack_flit(in_hdr, in_payload);
            buf_vc_d    = qos_to_vc(in_qos);
        end
    end

    // State registers; reset discards any buffered flit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_flit_q  <= '0;
            buf_vc_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
            crd_err_q   <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_flit_q  <= buf_flit_d;
            buf_vc_q    <= buf_vc_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_vc_q    <= out_vc_d;
            crd_err_q   <= crd_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_vc    = out_vc_q;
    assign crd_err   = crd_err_q;

endmodule

// File: tb/tb_flit_encoder.sv
// Directed testbench for flit_encoder: packing, VC mapping, credit flow, ordering, reset.
module tb_flit_encoder;
    import noc_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [NODE_ID_W-1:0] local_id;
    logic                 in_valid;
    logic                 in_ready;
    logic [NODE_ID_W-1:0] in_tgt_id;
    logic [TXN_ID_W-1:0]  in_txn_id;
    logic [QOS_W-1:0]     in_qos;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic [FLIT_LEN-1:0]  out_flit;
    logic [VC_ID_W-1:0]   out_vc;
    logic                 crd_rtn_valid;
    logic [VC_ID_W-1:0]   crd_rtn_vc;
    logic                 crd_err;

    int checks = 0;
    int errors = 0;

    flit_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .local_id      (local_id),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_tgt_id     (in_tgt_id),
        .in_txn_id     (in_txn_id),
        .in_qos        (in_qos),
        .in_payload    (in_payload),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .out_vc        (out_vc),
        .crd_rtn_valid (crd_rtn_valid),
        .crd_rtn_vc    (crd_rtn_vc),
        .crd_err       (crd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_tgt_id     = '0;
        in_txn_id     = '0;
        in_qos        = '0;
        in_payload    = '0;
        crd_rtn_valid = 1'b0;
        crd_rtn_vc    = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send(input logic [3:0] qos, input logic [6:0] tgt, input logic [11:0] txn);
        in_valid   = 1'b1;
        in_qos     = qos;
        in_tgt_id  = tgt;
        in_txn_id  = txn;
        in_payload = {{(PAYLOAD_W-32){1'b0}}, 20'hC0DE0, txn};
    endtask

    // Offers n requests on consecutive cycles, then idles; counts launch strobes
    task automatic burst(input logic [3:0] qos, input int n, input int extra,
                         output int launches);
        launches = 0;
        for (int i = 0; i < n; i++) begin
            send(qos, 7'h11, 12'(12'h500 + i));
            step();
            if (out_valid) launches++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < extra; i++) begin
            step();
            if (out_valid) launches++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (out_flit !== '0) begin
            errors++; $display("FAIL reset_out_flit: got %h, required 0", out_flit);
        end
        checks++;
        if (out_vc !== 3'd0) begin
            errors++; $display("FAIL reset_out_vc: got %0d, required 0", out_vc);
        end
        checks++;
        if (crd_err !== 1'b0) begin
            errors++; $display("FAIL reset_crd_err: got %b, required 0", crd_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [PAYLOAD_W-1:0] exp_pl;
        exp_pl = {{(PAYLOAD_W-32){1'b0}}, 20'hC0DE0, 12'hABC};
        send(4'h5, 7'h23, 12'hABC);
        step();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: out_valid got %b, required 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL single_launch: out_valid got %b, required 1", out_valid);
        end
        checks++;
        if (out_vc !== 3'd2) begin
            errors++; $display("FAIL single_vc: got %0d, required 2", out_vc);
        end
        checks++;
        if (out_flit[29:26] !== 4'h5) begin
            errors++; $display("FAIL single_qos: got %h, required 5", out_flit[29:26]);
        end
        checks++;
        if (out_flit[25:14] !== 12'hABC) begin
            errors++; $display("FAIL single_txn: got %h, required abc", out_flit[25:14]);
        end
        checks++;
        if (out_flit[6:0] !== 7'h23) begin
            errors++; $display("FAIL single_tgt: got %h, required 23", out_flit[6:0]);
        end
        checks++;
        if (out_flit[13:7] !== 7'h4A) begin
            errors++; $display("FAIL single_src: got %h, required 4a", out_flit[13:7]);
        end
        checks++;
        if (out_flit[FLIT_LEN-1:30] !== exp_pl) begin
            errors++; $display("FAIL single_payload: got %h, required %h",
                               out_flit[FLIT_LEN-1:30], exp_pl);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_flit[25:14] !== 12'hABC) begin
            errors++; $display("FAIL single_strobe_hold: valid %b txn %h, required 0 / abc",
                               out_valid, out_flit[25:14]);
        end
    endtask

    task automatic test_back_to_back();
        int launches;
        logic [11:0] exp_txn;
        apply_reset();
        launches = 0;
        exp_txn  = 12'h000;
        for (int i = 0; i < 5; i++) begin
            send(4'h0, 7'h10, 12'(i));
            step();
            if (out_valid) begin
                launches++;
                checks++;
                if (out_flit[25:14] !== exp_txn || out_vc !== 3'd0) begin
                    errors++; $display("FAIL b2b_order: txn %h vc %0d, required %h / 0",
                                       out_flit[25:14], out_vc, exp_txn);
                end
                exp_txn = exp_txn + 12'h1;
            end
        end
        idle_inputs();
        checks++;
        if (launches != 4) begin
            errors++; $display("FAIL b2b_launches: got %0d, required 4", launches);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_stall_ready: got %b, required 0", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_stall_valid: got %b, required 0", out_valid);
        end
        crd_rtn_valid = 1'b1;
        crd_rtn_vc    = 3'd0;
        step();
        crd_rtn_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_after_return: ready %b valid %b, required 1 / 0",
                               in_ready, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_flit[25:14] !== 12'h004 || out_vc !== 3'd0) begin
            errors++; $display("FAIL b2b_fifth: valid %b txn %h vc %0d, required 1 / 004 / 0",
                               out_valid, out_flit[25:14], out_vc);
        end
    endtask

    // Relies on VC0 being out of credits after test_back_to_back
    task automatic test_no_bypass();
        int early;
        send(4'h0, 7'h12, 12'h100);
        step();
        send(4'hF, 7'h13, 12'h200);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL nobypass_ready: got %b, required 0", in_ready);
        end
        early = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid || in_ready) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL nobypass_hold: got %0d active cycles, required 0", early);
        end
        crd_rtn_valid = 1'b1;
        crd_rtn_vc    = 3'd0;
        step();
        crd_rtn_valid = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_vc !== 3'd0 || out_flit[25:14] !== 12'h100) begin
            errors++; $display("FAIL nobypass_first: valid %b vc %0d txn %h, required 1/0/100",
                               out_valid, out_vc, out_flit[25:14]);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_vc !== 3'd7 || out_flit[25:14] !== 12'h200 ||
            out_flit[29:26] !== 4'hF) begin
            errors++; $display("FAIL nobypass_second: valid %b vc %0d txn %h, required 1/7/200",
                               out_valid, out_vc, out_flit[25:14]);
        end
    endtask

    task automatic test_same_cycle_return();
        int launches;
        apply_reset();
        send(4'h6, 7'h20, 12'h300);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_vc !== 3'd3) begin
            errors++; $display("FAIL same_first: valid %b vc %0d, required 1 / 3", out_valid, out_vc);
        end
        send(4'h7, 7'h20, 12'h301);
        step();
        in_valid      = 1'b0;
        crd_rtn_valid = 1'b1;
        crd_rtn_vc    = 3'd3;
        step();
        crd_rtn_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || crd_err !== 1'b0) begin
            errors++; $display("FAIL same_second: valid %b err %b, required 1 / 0",
                               out_valid, crd_err);
        end
        // Three credits left on VC3: three more launches, fourth request held
        burst(4'h6, 4, 4, launches);
        checks++;
        if (launches != 3) begin
            errors++; $display("FAIL same_count: got %0d launches, required 3", launches);
        end
        checks++;
        if (in_ready !== 1'b0 || crd_err !== 1'b0) begin
            errors++; $display("FAIL same_final: ready %b err %b, required 0 / 0",
                               in_ready, crd_err);
        end
    endtask

    task automatic test_overflow();
        int launches;
        apply_reset();
        crd_rtn_valid = 1'b1;
        crd_rtn_vc    = 3'd6;
        step();
        crd_rtn_valid = 1'b0;
        checks++;
        if (crd_err !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b, required 1", crd_err);
        end
        step();
        step();
        step();
        checks++;
        if (crd_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b, required 1", crd_err);
        end
        burst(4'hC, 5, 4, launches);
        checks++;
        if (launches != 4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_saturate: launches %0d ready %b, required 4 / 0",
                               launches, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        int launches;
        apply_reset();
        send(4'h2, 7'h30, 12'h400);
        step();
        send(4'h3, 7'h30, 12'h401);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: out_valid got %b, required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_flit !== '0) begin
            errors++; $display("FAIL midrst_async: valid %b ready %b flit0 %b, required 0/1/1",
                               out_valid, in_ready, (out_flit == '0));
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_discard: out_valid got %b, required 0", out_valid);
        end
        burst(4'h2, 5, 4, launches);
        checks++;
        if (launches != 4) begin
            errors++; $display("FAIL midrst_credits: got %0d launches, required 4", launches);
        end
    endtask

    initial begin
        local_id = 7'h4A;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_no_bypass();
        test_same_cycle_return();
        test_overflow();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
